branch_resolve_queue: RTL and testbench

- Downstream partner of the 2-bit saturating-counter predictor.
- Holds issued predictions in order until each branch resolves.
- At resolution, compares the stored prediction with the actual outcome and drives the predictor's update inputs (result/taken).
- Flags mispredictions, squashes wrong-path entries and keeps saturating accuracy statistics.

---
 rtl/branch_resolve_queue.sv | 105 ++++++++++
 tb/tb_branch_resolve_queue.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: holds issued predictions in order, compares each with
// the actual outcome at resolution, drives predictor update, squashes the
// wrong path on a mispredict and keeps saturating accuracy statistics.
module branch_resolve_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_valid,
  input  logic             pred_taken,
  output logic             pred_ready,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  output logic             update_valid,
  output logic             update_taken,
  output logic             mispredict,
  output logic             resolve_err,
  output logic [PTR_W:0]   count,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam logic [PTR_W:0] Full = (PTR_W + 1)'(DEPTH);

  logic [DEPTH-1:0] entry_q, entry_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic             upd_valid_q, upd_taken_q, mispredict_q, resolve_err_q;

  logic res_hit, res_empty, res_miss, push;

  // Decode this cycle's push/resolve and compute next pointers, entries and counters.
  always_comb begin
    pred_ready = (count_q != Full);
    res_hit    = resolve_valid && (count_q != '0);
    res_empty  = resolve_valid && (count_q == '0);
    res_miss   = res_hit && (entry_q[head_q] != resolve_taken);
    // A full queue still takes a push when a correct resolve frees the slot
    // in the same cycle; everything issued alongside a mispredict is squashed.
    push       = pred_valid && (pred_ready || res_hit) && !res_miss;

    entry_d = entry_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (res_miss) begin
      head_d  = head_q + PTR_W'(1);
      tail_d  = head_q + PTR_W'(1);
      count_d = '0;
    end else begin
      if (push) begin
        entry_d[tail_q] = pred_taken;
        tail_d          = tail_q + PTR_W'(1);
      end
      if (res_hit) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(res_hit);
    end

    total_d = (res_hit && (total_q != '1)) ? total_q + CNT_W'(1) : total_q;
    miss_d  = (res_miss && (miss_q != '1)) ? miss_q + CNT_W'(1) : miss_q;
  end

  // State and registered one-cycle output pulses; reset wins over any activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      total_q       <= '0;
      miss_q        <= '0;
      upd_valid_q   <= 1'b0;
      upd_taken_q   <= 1'b0;
      mispredict_q  <= 1'b0;
      resolve_err_q <= 1'b0;
    end else begin
      entry_q       <= entry_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      total_q       <= total_d;
      miss_q        <= miss_d;
      upd_valid_q   <= res_hit;
      upd_taken_q   <= res_hit && resolve_taken;
      mispredict_q  <= res_miss;
      resolve_err_q <= res_empty;
    end
  end

  assign update_valid = upd_valid_q;
  assign update_taken = upd_taken_q;
  assign mispredict   = mispredict_q;
  assign resolve_err  = resolve_err_q;
  assign count        = count_q;
  assign total_cnt    = total_q;
  assign miss_cnt     = miss_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: a queue model predicts each
// cycle's outputs, which are pushed to a scoreboard and compared after the edge.
module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        reset, pred_valid, pred_taken, resolve_valid, resolve_taken;
  logic        pred_ready, update_valid, update_taken, mispredict, resolve_err;
  logic [2:0]  count;
  logic [15:0] total_cnt, miss_cnt;
  logic        s_pred_ready, s_update_valid, s_update_taken, s_mispredict, s_resolve_err;
  logic [2:0]  s_count;
  logic [1:0]  s_total_cnt, s_miss_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    logic        uv, ut, mp, re;
    logic [2:0]  cnt;
    logic [15:0] tot, mis;
    logic [1:0]  tot2, mis2;
  } exp_t;

  exp_t        exp_q[$];
  logic        mq[$];       // model of queue contents, oldest first
  logic [15:0] m_tot, m_mis;
  logic [1:0]  m_tot2, m_mis2;

  always #5 clk = ~clk;

  branch_resolve_queue #(.DEPTH(4), .PTR_W(2), .CNT_W(16)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .pred_valid   (pred_valid),
    .pred_taken   (pred_taken),
    .pred_ready   (pred_ready),
    .resolve_valid(resolve_valid),
    .resolve_taken(resolve_taken),
    .update_valid (update_valid),
    .update_taken (update_taken),
    .mispredict   (mispredict),
    .resolve_err  (resolve_err),
    .count        (count),
    .total_cnt    (total_cnt),
    .miss_cnt     (miss_cnt)
  );

  branch_resolve_queue #(.DEPTH(4), .PTR_W(2), .CNT_W(2)) u_dut_small (
    .clk          (clk),
    .reset        (reset),
    .pred_valid   (pred_valid),
    .pred_taken   (pred_taken),
    .pred_ready   (s_pred_ready),
    .resolve_valid(resolve_valid),
    .resolve_taken(resolve_taken),
    .update_valid (s_update_valid),
    .update_taken (s_update_taken),
    .mispredict   (s_mispredict),
    .resolve_err  (s_resolve_err),
    .count        (s_count),
    .total_cnt    (s_total_cnt),
    .miss_cnt     (s_miss_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle of stimulus: model predicts, scoreboard compares after the edge.
  task automatic step(input logic pv, input logic pt, input logic rv, input logic rt);
    exp_t e;
    logic ok, head, push;
    @(negedge clk);
    reset = 1'b0;
    pred_valid = pv; pred_taken = pt; resolve_valid = rv; resolve_taken = rt;
    check("pred_ready", {31'd0, pred_ready}, {31'd0, mq.size() != 4});
    ok   = rv && (mq.size() > 0);
    head = ok ? mq[0] : 1'b0;
    e.uv = ok;
    e.ut = ok && rt;
    e.mp = ok && (head != rt);
    e.re = rv && (mq.size() == 0);
    push = pv && ((mq.size() != 4) || ok);
    if (ok) begin
      if (m_tot != 16'hffff) m_tot++;
      if (m_tot2 != 2'd3) m_tot2++;
    end
    if (e.mp) begin
      if (m_mis != 16'hffff) m_mis++;
      if (m_mis2 != 2'd3) m_mis2++;
      mq.delete();
    end else begin
      if (ok) void'(mq.pop_front());
      if (push) mq.push_back(pt);
    end
    e.cnt = 3'(mq.size());
    e.tot = m_tot; e.mis = m_mis; e.tot2 = m_tot2; e.mis2 = m_mis2;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("update_valid", {31'd0, update_valid}, {31'd0, e.uv});
    if (e.uv) check("update_taken", {31'd0, update_taken}, {31'd0, e.ut});
    check("mispredict", {31'd0, mispredict}, {31'd0, e.mp});
    check("resolve_err", {31'd0, resolve_err}, {31'd0, e.re});
    check("count", {29'd0, count}, {29'd0, e.cnt});
    check("total_cnt", {16'd0, total_cnt}, {16'd0, e.tot});
    check("miss_cnt", {16'd0, miss_cnt}, {16'd0, e.mis});
    check("small_total_cnt", {30'd0, s_total_cnt}, {30'd0, e.tot2});
    check("small_miss_cnt", {30'd0, s_miss_cnt}, {30'd0, e.mis2});
  endtask

  // Reset cycle with push (and optionally resolve) active; all must be ignored.
  task automatic do_reset(input logic rv);
    @(negedge clk);
    reset = 1'b1;
    pred_valid = 1'b1; pred_taken = 1'b1; resolve_valid = rv; resolve_taken = 1'b0;
    @(posedge clk);
    #1;
    check("rst_update_valid", {31'd0, update_valid}, 32'd0);
    check("rst_update_taken", {31'd0, update_taken}, 32'd0);
    check("rst_mispredict", {31'd0, mispredict}, 32'd0);
    check("rst_resolve_err", {31'd0, resolve_err}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_total_cnt", {16'd0, total_cnt}, 32'd0);
    check("rst_miss_cnt", {16'd0, miss_cnt}, 32'd0);
    check("rst_small_total", {30'd0, s_total_cnt}, 32'd0);
    reset = 1'b0;
    mq.delete();
    m_tot = '0; m_mis = '0; m_tot2 = '0; m_mis2 = '0;
  endtask

  task automatic resolve_ok();
    step(1'b0, 1'b0, 1'b1, mq[0]);
  endtask

  initial begin
    reset = 1'b1;
    pred_valid = 1'b0; pred_taken = 1'b0; resolve_valid = 1'b0; resolve_taken = 1'b0;
    m_tot = '0; m_mis = '0; m_tot2 = '0; m_mis2 = '0;
    repeat (2) @(posedge clk);
    do_reset(1'b0);

    // 1: in-order push/resolve, back-to-back update pulses
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
    step(0, 0, 1, 1); step(0, 0, 1, 0); step(0, 0, 1, 1);
    step(0, 0, 0, 0);

    // 2: fill, drop when full, correct resolve with push while full
    step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    repeat (4) resolve_ok();
    step(0, 0, 0, 0);

    // 3: mispredict squashes younger entries, then empty resolve errors
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);

    // 4: empty resolve with simultaneous push
    step(1, 1, 1, 0);
    step(0, 0, 1, 1);

    // 5: reset mid-operation, then pointer wrap with data order
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1, 1'($urandom_range(0, 1)), 0, 0);
      resolve_ok();
    end
    for (int i = 0; i < 6; i++) begin
      if (mq.size() > 0) step(1, 1'($urandom_range(0, 1)), 1, mq[0]);
      else step(1, 1'($urandom_range(0, 1)), 0, 0);
    end

    // 6: saturation of the narrow counters
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 0);
      step(0, 0, 1, 0);
    end
    check("small_total_sat", {30'd0, s_total_cnt}, 32'd3);
    check("small_miss_sat", {30'd0, s_miss_cnt}, 32'd3);

    pred_valid = 1'b0; resolve_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
